// File: rtl/snd_stream_parser.sv
`timescale 1ns/1ps
// snd_stream_parser
// Byte-stream decoder for Sun/NeXT ".snd" audio files. Validates and latches
// the 24-byte big-endian header, skips to the data offset, then emits signed
// 16-bit PCM samples tagged with a rotating channel index.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_data/in_valid/in_ready   file byte stream (transfer on valid && ready)
//   hdr_valid               header accepted; sample_rate/channels/enc16 stable
//   sample_rate, channels, enc16   latched header fields
//   out_sample/out_chan/out_valid/out_ready   PCM output stream
//   done                    declared data size fully consumed
//   err                     header rejected
//
// Optional feature macro: SND_SIZE_CHECK_EN
//   defined   -> the header data size is honoured and DONE is reachable
//   undefined -> size is parsed but ignored, done is tied to 0, DATA runs
//                until reset and no remaining-byte counter is built
module snd_stream_parser #(
  parameter int unsigned MIN_OFFSET = 24,
  parameter int unsigned CH_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            hdr_valid,
  output logic [31:0]     sample_rate,
  output logic [CH_W-1:0] channels,
  output logic            enc16,
  output logic [15:0]     out_sample,
  output logic [CH_W-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done,
  output logic            err
);

  typedef enum logic [3:0] {
    S_MAGIC, S_OFFSET, S_SIZE, S_ENC, S_RATE, S_CHAN, S_SKIP, S_DATA, S_DONE, S_ERROR
  } state_t;

  // Largest channel index representable in CH_W bits.
  localparam logic [31:0] CH_MAX = (CH_W >= 32) ? 32'hFFFF_FFFF
                                                : 32'((64'd1 << CH_W) - 64'd1);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [23:0]     sh_q, sh_d;         // first three bytes of the current header word
  logic [31:0]     skip_q, skip_d;     // holds the offset, then the bytes left to skip
  logic [31:0]     rate_q, rate_d;
  logic [CH_W-1:0] channels_q, channels_d;
  logic [CH_W-1:0] last_chan_q, last_chan_d;
  logic            enc16_q, enc16_d;
  logic [7:0]      hi_q, hi_d;
  logic            have_hi_q, have_hi_d;
  logic [15:0]     sample_q, sample_d;
  logic            out_valid_q, out_valid_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic            err_q, err_d;
  logic            alive_q, alive_d;   // low only on the cycle(s) right after reset

  logic [31:0] word;
  logic [31:0] chan_m1;
  logic [31:0] skip_m24;
  logic        accept;
  logic        xfer;
  logic        last_byte;
  logic        data_end;
  logic        hdr_end;
  logic [7:0]  magic_byte;

`ifdef SND_SIZE_CHECK_EN
  logic [31:0] rem_q, rem_d;           // data bytes still to come (valid when !unknown_q)
  logic        unknown_q, unknown_d;
  logic        done_q, done_d;
  assign data_end = !unknown_q && (rem_q == 32'd0);
  assign done     = done_q;
`else
  assign data_end = 1'b0;
  assign done     = 1'b0;
`endif

  assign word      = {sh_q, in_data};
  assign chan_m1   = word - 32'd1;
  assign skip_m24  = skip_q - 32'd24;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;
  assign last_byte = (cnt_q == 2'd3);

  always_comb begin
    case (cnt_q)
      2'd0:    magic_byte = 8'h2E;
      2'd1:    magic_byte = 8'h73;
      2'd2:    magic_byte = 8'h6E;
      default: magic_byte = 8'h64;
    endcase
  end

  // Header/skip states always take a byte; in DATA the completing byte of a
  // sample needs room in the single-entry output register. Once the known
  // size is exhausted nothing more is taken until the last sample leaves.
  always_comb begin
    in_ready = 1'b0;
    if (alive_q) begin
      if (state_q == S_DATA) begin
        if (data_end)                  in_ready = 1'b0;
        else if (enc16_q && !have_hi_q) in_ready = 1'b1;
        else                           in_ready = !out_valid_q || out_ready;
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    skip_d      = skip_q;
    rate_d      = rate_q;
    channels_d  = channels_q;
    last_chan_d = last_chan_q;
    enc16_d     = enc16_q;
    hi_d        = hi_q;
    have_hi_d   = have_hi_q;
    sample_d    = sample_q;
    out_valid_d = out_valid_q;
    chan_d      = chan_q;
    hdr_valid_d = hdr_valid_q;
    err_d       = err_q;
    alive_d     = 1'b1;
    hdr_end     = 1'b0;
`ifdef SND_SIZE_CHECK_EN
    rem_d       = rem_q;
    unknown_d   = unknown_q;
    done_d      = done_q;
`endif

    if (xfer) begin
      out_valid_d = 1'b0;
      chan_d      = (chan_q == last_chan_q) ? '0 : chan_q + CH_W'(1);
    end

    if (accept && (state_q inside {S_MAGIC, S_OFFSET, S_SIZE, S_ENC, S_RATE, S_CHAN})) begin
      sh_d  = word[23:0];
      cnt_d = cnt_q + 2'd1;
    end

    case (state_q)
      S_MAGIC: if (accept) begin
        if (in_data != magic_byte) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (last_byte) begin
          state_d = S_OFFSET;
        end
      end
      S_OFFSET: if (accept && last_byte) begin
        skip_d = word;
        if (word < MIN_OFFSET) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          state_d = S_SIZE;
        end
      end
      S_SIZE: if (accept && last_byte) begin
`ifdef SND_SIZE_CHECK_EN
        rem_d     = word;
        unknown_d = &word;
`endif
        state_d = S_ENC;
      end
      S_ENC: if (accept && last_byte) begin
        if (word == 32'd2 || word == 32'd3) begin
          enc16_d = word[0];
          state_d = S_RATE;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_RATE: if (accept && last_byte) begin
        rate_d  = word;
        state_d = S_CHAN;
      end
      S_CHAN: if (accept && last_byte) begin
        if (word == 32'd0) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          channels_d = word[CH_W-1:0];
          // Wrap point saturates when the count exceeds the index width.
          last_chan_d = (chan_m1 > CH_MAX) ? '1 : chan_m1[CH_W-1:0];
          skip_d      = skip_m24;
          if (skip_m24 == 32'd0) hdr_end = 1'b1;
          else                   state_d = S_SKIP;
        end
      end
      S_SKIP: if (accept) begin
        skip_d = skip_q - 32'd1;
        if (skip_q == 32'd1) hdr_end = 1'b1;
      end
      S_DATA: begin
        if (data_end) begin
          have_hi_d = 1'b0;  // an odd trailing high byte is dropped here
          if (!out_valid_q || out_ready) begin
            state_d = S_DONE;
`ifdef SND_SIZE_CHECK_EN
            done_d  = 1'b1;
`endif
          end
        end else if (accept) begin
`ifdef SND_SIZE_CHECK_EN
          if (!unknown_q) rem_d = rem_q - 32'd1;
`endif
          if (enc16_q && !have_hi_q) begin
            hi_d      = in_data;
            have_hi_d = 1'b1;
          end else begin
            sample_d    = enc16_q ? {hi_q, in_data} : {in_data, 8'h00};
            out_valid_d = 1'b1;
            have_hi_d   = 1'b0;
          end
        end
      end
      default: ;  // DONE and ERROR drain input until reset
    endcase

    if (hdr_end) begin
      hdr_valid_d = 1'b1;
      have_hi_d   = 1'b0;
      if (data_end) begin
        state_d = S_DONE;
`ifdef SND_SIZE_CHECK_EN
        done_d  = 1'b1;
`endif
      end else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_MAGIC;
      cnt_q       <= '0;
      sh_q        <= '0;
      skip_q      <= '0;
      rate_q      <= '0;
      channels_q  <= '0;
      last_chan_q <= '0;
      enc16_q     <= 1'b0;
      hi_q        <= '0;
      have_hi_q   <= 1'b0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      chan_q      <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
`ifdef SND_SIZE_CHECK_EN
      rem_q       <= '0;
      unknown_q   <= 1'b0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      skip_q      <= skip_d;
      rate_q      <= rate_d;
      channels_q  <= channels_d;
      last_chan_q <= last_chan_d;
      enc16_q     <= enc16_d;
      hi_q        <= hi_d;
      have_hi_q   <= have_hi_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
      chan_q      <= chan_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      alive_q     <= alive_d;
`ifdef SND_SIZE_CHECK_EN
      rem_q       <= rem_d;
      unknown_q   <= unknown_d;
      done_q      <= done_d;
`endif
    end
  end

  assign hdr_valid   = hdr_valid_q;
  assign sample_rate = rate_q;
  assign channels    = channels_q;
  assign enc16       = enc16_q;
  assign out_sample  = sample_q;
  assign out_chan    = chan_q;
  assign out_valid   = out_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_snd_stream_parser.sv
`timescale 1ns/1ps
module tb_snd_stream_parser;

  localparam int CH_W = 8;
`ifdef SND_SIZE_CHECK_EN
  localparam bit SIZE_EN = 1'b1;
`else
  localparam bit SIZE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            hdr_valid;
  logic [31:0]     sample_rate;
  logic [CH_W-1:0] channels;
  logic            enc16;
  logic [15:0]     out_sample;
  logic [CH_W-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
  logic            done;
  logic            err;

  snd_stream_parser #(.MIN_OFFSET(24), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hdr_valid(hdr_valid), .sample_rate(sample_rate), .channels(channels), .enc16(enc16),
    .out_sample(out_sample), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     s;
    logic [CH_W-1:0] c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  // Scoreboard: a transfer is certain at the next rising edge when both
  // handshake signals are high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sample=%h chan=%0d, required no output", out_sample, out_chan);
      end else begin
        e = sb.pop_front();
        if (out_sample !== e.s || out_chan !== e.c) begin
          errors++;
          $display("FAIL sample: got %h/chan %0d, required %h/chan %0d", out_sample, out_chan, e.s, e.c);
        end else begin
          $display("out sample=%h chan=%0d", out_sample, out_chan);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] s, input logic [CH_W-1:0] c);
    exp_t e;
    e.s = s;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted in 100 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [31:0] off, input logic [31:0] size, input logic [31:0] enc,
                          input logic [31:0] rate, input logic [31:0] ch);
    send_word(32'h2E736E64);
    send_word(off);
    send_word(size);
    send_word(enc);
    send_word(rate);
    send_word(ch);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) idle(1);
    idle(2);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++;
    if ({hdr_valid, enc16, out_valid, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 00000", {hdr_valid, enc16, out_valid, done, err});
    end
    checks++;
    if ({sample_rate, channels, out_sample, out_chan} !== '0) begin
      errors++; $display("FAIL reset_fields: got rate=%h ch=%h smp=%h chan=%h, required all 0", sample_rate, channels, out_sample, out_chan);
    end
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_enc16_basic();
    send_hdr(32'h20, 32'hFFFFFFFF, 32'd3, 32'h1000, 32'd2);
    checks++;
    if (hdr_valid !== 1'b0) begin errors++; $display("FAIL hdr_valid_in_skip: got %b, required 0", hdr_valid); end
    repeat (8) send_byte(8'h00);
    checks++;
    if (hdr_valid !== 1'b1) begin errors++; $display("FAIL hdr_valid_after_skip: got %b, required 1", hdr_valid); end
    checks++;
    if (sample_rate !== 32'd4096 || channels !== 8'd2 || enc16 !== 1'b1) begin
      errors++; $display("FAIL hdr_fields: got rate=%0d ch=%0d enc16=%b, required 4096 2 1", sample_rate, channels, enc16);
    end
    push_exp(16'h1234, 8'd0);
    push_exp(16'hABCD, 8'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL enc16_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL enc16_status: got done=%b err=%b, required 0 0", done, err); end
  endtask

  task automatic test_enc8_size();
    do_reset();
    send_hdr(32'd24, 32'd3, 32'd2, 32'd8000, 32'd1);
    push_exp(16'h4000, 8'd0);
    push_exp(16'h8000, 8'd0);
    push_exp(16'h7F00, 8'd0);
    send_byte(8'h40); send_byte(8'h80); send_byte(8'h7F);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL enc8_done_early: got %b, required 0", done); end
    if (!SIZE_EN) push_exp(16'h5500, 8'd0);
    send_byte(8'h55);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL enc8_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
    checks++;
    if (done !== SIZE_EN) begin errors++; $display("FAIL enc8_done: got %b, required %b", done, SIZE_EN); end
    checks++;
    if (enc16 !== 1'b0 || hdr_valid !== 1'b1) begin errors++; $display("FAIL enc8_hdr: got enc16=%b hdr_valid=%b, required 0 1", enc16, hdr_valid); end
  endtask

  task automatic test_bad_magic();
    int snap;
    do_reset();
    send_byte(8'h2E); send_byte(8'h73); send_byte(8'h6E);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL magic_err_early: got %b, required 0", err); end
    send_byte(8'h65);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL magic_err: got %b, required 1", err); end
    snap = n_out;
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
    checks++;
    if (n_out != snap || hdr_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL magic_drain: got outs=%0d hdr_valid=%b in_ready=%b err=%b, required 0 0 1 1", n_out - snap, hdr_valid, in_ready, err);
    end
  endtask

  task automatic test_bad_fields();
    do_reset();
    send_hdr(32'd24, 32'd4, 32'd1, 32'd8000, 32'd1);
    checks++;
    if (err !== 1'b1 || hdr_valid !== 1'b0) begin errors++; $display("FAIL bad_enc: got err=%b hdr_valid=%b, required 1 0", err, hdr_valid); end
    do_reset();
    send_hdr(32'd16, 32'd4, 32'd2, 32'd8000, 32'd1);
    checks++;
    if (err !== 1'b1 || hdr_valid !== 1'b0) begin errors++; $display("FAIL bad_offset: got err=%b hdr_valid=%b, required 1 0", err, hdr_valid); end
  endtask

  task automatic test_size_zero();
    do_reset();
    send_hdr(32'd24, 32'd0, 32'd2, 32'd8000, 32'd1);
    checks++;
    if (hdr_valid !== 1'b1 || done !== SIZE_EN) begin
      errors++; $display("FAIL size_zero: got hdr_valid=%b done=%b, required 1 %b", hdr_valid, done, SIZE_EN);
    end
    if (!SIZE_EN) push_exp(16'hAA00, 8'd0);
    send_byte(8'hAA);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL size_zero_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    int snap;
    do_reset();
    send_hdr(32'd24, 32'd5, 32'd3, 32'd44100, 32'd3);
    snap = n_out;
    push_exp(16'h1122, 8'd0);
    push_exp(16'h3344, 8'd1);
    out_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    in_data  = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b, required 0", i, in_ready); end
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_sample !== 16'h1122 || out_chan !== 8'd0) begin
      errors++; $display("FAIL stall_hold: got v=%b %h chan %0d, required 1 1122 chan 0", out_valid, out_sample, out_chan);
    end
    out_ready = 1'b1;
    send_byte(8'h44);
    send_byte(8'h55);
    wait_drain();
    idle(4);
    checks++;
    if (n_out - snap != 2) begin errors++; $display("FAIL bp_count: got %0d outputs, required 2", n_out - snap); end
    checks++;
    if (done !== SIZE_EN) begin errors++; $display("FAIL bp_done: got %b, required %b", done, SIZE_EN); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_hdr(32'd24, 32'hFFFFFFFF, 32'd2, 32'd8000, 32'd3);
    push_exp(16'h1000, 8'd0);
    send_byte(8'h10);
    wait_drain();
    checks++;
    if (out_chan !== 8'd1) begin errors++; $display("FAIL pre_reset_chan: got %0d, required 1", out_chan); end
    do_reset();
    send_hdr(32'd32, 32'hFFFFFFFF, 32'd3, 32'd8000, 32'd2);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    do_reset();
    checks++;
    if (hdr_valid !== 1'b0 || out_chan !== 8'd0) begin
      errors++; $display("FAIL mid_reset_state: got hdr_valid=%b chan=%0d, required 0 0", hdr_valid, out_chan);
    end
    send_hdr(32'd24, 32'hFFFFFFFF, 32'd2, 32'd22050, 32'd3);
    checks++;
    if (hdr_valid !== 1'b1 || sample_rate !== 32'd22050 || channels !== 8'd3 || enc16 !== 1'b0) begin
      errors++; $display("FAIL fresh_hdr: got v=%b rate=%0d ch=%0d enc16=%b, required 1 22050 3 0", hdr_valid, sample_rate, channels, enc16);
    end
    push_exp(16'h0100, 8'd0);
    push_exp(16'h0200, 8'd1);
    push_exp(16'h0300, 8'd2);
    push_exp(16'h0400, 8'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL fresh_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_enc16_basic();
    test_enc8_size();
    test_bad_magic();
    test_bad_fields();
    test_size_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
